id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
// - ID/EX pipeline register plus interlock control for one core of the quad-core MIPS pipeline.
// - Captures the decode bundle and supplies idExRs/idExRt/idExRd to the forwarding unit and the EX stage.
// - Detects load-use hazards and inserts bubbles.
// - Sequences multi-cycle mul/div occupancy, back-pressure hold and branch flush.
// PARAMETERS
// - WIDTH       32  datapath width of operand/immediate fields
// - MULDIV_LAT  4   EX-occupancy cycles of a mul/div op (>=2)
// PORTS
// - CLK          in   1      clock, rising edge
// - nRST         in   1      asynchronous active-low reset
// - idValid      in   1      decode slot holds a real instruction
// - idRs         in   5      decode source register Rs
// - idRt         in   5      decode source register Rt
// - idRd         in   5      decode destination register
// - idRegW       in   1      decode instruction writes the register file
// - idMemRead    in   1      decode instruction is a load
// - idMulDiv     in   1      decode instruction is mul/div
// - idRsData     in   WIDTH  register-file read data for Rs
// - idRtData     in   WIDTH  register-file read data for Rt
// - idImm        in   WIDTH  sign-extended immediate
// - exMemHold    in   1      downstream stall: the memory stage cannot accept
// - flush        in   1      branch/jump redirect: squash the decode slot
// - idStall      out  1      freeze PC and IF/ID (combinational)
// - idExValid    out  1      registered copy of the decode bundle; same registering for Rs..Imm below
// - idExRs, idExRt, idExRd  out  5      registered register numbers
// - idExRegW, idExMemRead   out  1      registered control bits
// - idExRsData, idExRtData, idExImm  out  WIDTH  registered data and immediate
// - idExBusy     out  1      mul/div occupies EX (registered)
// BEHAVIOUR
// - Reset (async, nRST=0)
//   - All outputs and registers clear to 0; busy counter = 0.
//   - idStall = 0 while in reset.
// - Hazard signals
//   - loadUse = idValid & idExValid & idExMemRead & (idExRd!=0) & (idExRd==idRs | idExRd==idRt)
//   - busy = (cnt != 0)
// - Per-edge action, first matching rule wins:
//   1. flush: load a bubble (idExValid, idExRegW, idExMemRead = 0; other fields don't-care, cleared); cnt = 0; idStall = 0.
//   2. exMemHold: the ID/EX register holds all fields; cnt holds; idStall = 1.
//   3. busy: the register holds; cnt decrements by 1; idStall = 1.
//   4. loadUse: load a bubble; idStall = 1; the decode bundle is re-presented next cycle.
//   5. Otherwise: capture the decode bundle.
//      - idExValid = idValid.
//      - If idValid & idMulDiv, cnt = MULDIV_LAT-1.
//      - idStall = 0.
// - Latency and stall length
//   - Decode to ID/EX latency is 1 cycle.
//   - A load-use hazard costs exactly 1 bubble.
//   - A mul/div holds EX for MULDIV_LAT cycles total, plus any exMemHold cycles.
// - Boundary conditions
//   - flush during busy aborts the mul/div: cnt = 0 and idExBusy falls the next cycle.
//   - flush with exMemHold: flush wins.
//   - Rd=0 never triggers loadUse.
//   - A bubble (idExValid=0) never triggers loadUse.
//   - cnt never underflows.
//   - idExBusy = (cnt != 0) is registered; it is 0 in the cycle after cnt reaches 0.
// CONFIGURATION
// - Macro ID_EX_PERF_CNT_EN
//   - Defined: adds outputs perfLoadUse[31:0] and perfBusy[31:0].
//   - Both counters are cleared by nRST and wrap at 2^32.
//   - perfLoadUse increments in each cycle where rule 4 fires.
//   - perfBusy increments in each cycle where rule 3 fires.
//   - Not defined: the ports and logic are absent; all other behaviour is identical.
// TESTING
// - Reset: nRST=0 with random inputs -> every output 0; release -> first valid decode appears 1 cycle later.
// - Load-use: lw r5 in ID/EX, decode add uses r5 (idRs=5) -> idStall=1 for 1 cycle; bubble (idExValid=0); add captured the next cycle.
// - Rd zero: lw r0 then idRs=0 -> no stall; instruction captured immediately.
// - Mul/div, MULDIV_LAT=4: mult captured -> idExBusy=1 and idStall=1 for 3 cycles, register held; next op captured on cycle 4.
// - Hold vs flush: exMemHold=1 for 2 cycles -> fields frozen; flush asserted together with exMemHold -> bubble next cycle, idStall=0.
// - Perf (ID_EX_PERF_CNT_EN): 3 load-use events + 1 mult -> perfLoadUse=3, perfBusy=3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use, mul/div occupancy, hold and flush interlocks.
// Optional performance counters are enabled with `define ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             idValid,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic [4:0]       idRd,
  input  logic             idRegW,
  input  logic             idMemRead,
  input  logic             idMulDiv,
  input  logic [WIDTH-1:0] idRsData,
  input  logic [WIDTH-1:0] idRtData,
  input  logic [WIDTH-1:0] idImm,
  input  logic             exMemHold,
  input  logic             flush,
  output logic             idStall,
  output logic             idExValid,
  output logic [4:0]       idExRs,
  output logic [4:0]       idExRt,
  output logic [4:0]       idExRd,
  output logic             idExRegW,
  output logic             idExMemRead,
  output logic [WIDTH-1:0] idExRsData,
  output logic [WIDTH-1:0] idExRtData,
  output logic [WIDTH-1:0] idExImm,
  output logic             idExBusy
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]      perfLoadUse,
  output logic [31:0]      perfBusy
`endif
);

  localparam int unsigned CntW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  typedef struct packed {
    logic             valid;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic             reg_w;
    logic             mem_read;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm;
  } bundle_t;

  typedef enum logic [2:0] {ActFlush, ActHold, ActBusy, ActBubble, ActCapture} action_e;

  bundle_t         dec_bundle, bundle_d, bundle_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            load_use, busy, stall_raw;
  action_e         action;

  assign dec_bundle = '{valid: idValid, rs: idRs, rt: idRt, rd: idRd, reg_w: idRegW,
                        mem_read: idMemRead, rs_data: idRsData, rt_data: idRtData, imm: idImm};

  assign busy     = (cnt_q != '0);
  assign load_use = idValid & bundle_q.valid & bundle_q.mem_read & (bundle_q.rd != 5'd0) &
                    ((bundle_q.rd == idRs) | (bundle_q.rd == idRt));

  // Priority order: flush beats hold, hold beats mul/div countdown, countdown beats load-use.
  always_comb begin
    if (flush)          action = ActFlush;
    else if (exMemHold) action = ActHold;
    else if (busy)      action = ActBusy;
    else if (load_use)  action = ActBubble;
    else                action = ActCapture;
  end

  always_comb begin
    bundle_d  = bundle_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    unique case (action)
      ActFlush: begin
        bundle_d = '0;
        cnt_d    = '0;
      end
      ActHold: begin
        stall_raw = 1'b1;
      end
      ActBusy: begin
        cnt_d     = cnt_q - CntW'(1);
        stall_raw = 1'b1;
      end
      ActBubble: begin
        bundle_d  = '0;
        stall_raw = 1'b1;
      end
      ActCapture: begin
        bundle_d = dec_bundle;
        if (idValid && idMulDiv) cnt_d = CntW'(MULDIV_LAT - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bundle_q <= '0;
      cnt_q    <= '0;
    end else begin
      bundle_q <= bundle_d;
      cnt_q    <= cnt_d;
    end
  end

  // Reset forces the stall low even though hold/flush inputs may be toggling.
  assign idStall     = nRST & stall_raw;
  assign idExValid   = bundle_q.valid;
  assign idExRs      = bundle_q.rs;
  assign idExRt      = bundle_q.rt;
  assign idExRd      = bundle_q.rd;
  assign idExRegW    = bundle_q.reg_w;
  assign idExMemRead = bundle_q.mem_read;
  assign idExRsData  = bundle_q.rs_data;
  assign idExRtData  = bundle_q.rt_data;
  assign idExImm     = bundle_q.imm;
  assign idExBusy    = busy;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_load_use_q, perf_busy_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_load_use_q <= '0;
      perf_busy_q     <= '0;
    end else begin
      if (action == ActBubble) perf_load_use_q <= perf_load_use_q + 32'd1;
      if (action == ActBusy)   perf_busy_q     <= perf_busy_q + 32'd1;
    end
  end

  assign perfLoadUse = perf_load_use_q;
  assign perfBusy    = perf_busy_q;
`endif

endmodule
